nv_sync_toggle_evt: RTL and testbench
=====================================

// Module: nv_sync_toggle_evt
// PURPOSE
//  Destination-domain consumer of a 3-flop synchronizer: turns a synchronized toggle
//  (each transition = one source event) into a coalesced event count for the consumer.
//  The count is offered to a downstream consumer over a valid/ready handshake.
//  Sits directly after the synchronizer cell.
//  Lost events are flagged with a sticky overflow bit.
// PARAMETERS
//  CNT_W   4   width of pending-event counter; saturates at 2^CNT_W-1
// PORTS
//  clk       in   1      destination clock
//  clr       in   1      asynchronous, active-high reset
//  tgl_sync  in   1      synchronized toggle from synchronizer output
//  en        in   1      1: count edges; 0: edges dropped (tracking continues)
//  evt_rdy   in   1      consumer accepts evt_cnt this cycle
//  ovf_clr   in   1      clears sticky ovf
//  evt_vld   out  1      pending count nonzero
//  evt_cnt   out  CNT_W  number of events coalesced, valid when evt_vld
//  ovf       out  1      sticky: an edge arrived while counter saturated
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-high on clr.
//  - Reset: tgl_q=0, armed=0, pend=0, ovf=0; so evt_vld=0, evt_cnt=0, ovf=0.
//  - Arming: armed=0 for the first clk after clr deasserts; that edge loads tgl_q<=tgl_sync
//    and sets armed=1. While armed=0 no edge is counted, so post-reset level is never an event.
//  - Edge: edge = armed & en & (tgl_sync ^ tgl_q). tgl_q <= tgl_sync every cycle
//    regardless of en (re-enabling never creates a phantom event).
//  - Outputs are combinational from registers: evt_vld = (pend!=0), evt_cnt = pend.
//  - Latency: tgl_sync transitions before edge N -> evt_vld=1 after edge N (1 cycle).
//  - Accept: acc = evt_vld & evt_rdy. Next pend:
//      acc & edge   -> 1        (new event not merged into delivered batch)
//      acc & !edge  -> 0
//      !acc & edge  -> pend+1, or hold at max if pend==2^CNT_W-1
//      !acc & !edge -> pend
//  - evt_rdy while evt_vld=0 has no effect. evt_vld/evt_cnt stable until accepted or incremented.
//  - Overflow: set when !acc & edge & pend==max.
//  - ovf_clr alone -> ovf<=0. Set and clear in same cycle -> ovf=1 (set wins).
//  - Multiple toggles between samples are lost by construction: one edge per cycle max.
//  - clr mid-operation: pending count and ovf discarded immediately; re-arm as above.
// STRUCTURE
//  - Single module; no sub-module required.
//  - The saturating increment is inline (one comparator against {CNT_W{1'b1}}).
//  - Shared header/package: CNT_W default constant only; no typedefs needed.
// TESTING
//  1 Reset with tgl_sync=1, release, hold 10 cycles -> evt_vld stays 0, ovf=0.
//  2 en=1, evt_rdy=0, 3 toggles on successive cycles -> evt_cnt 1,2,3; then evt_rdy=1
//    for 1 cycle -> evt_vld=0 next cycle.
//  3 pend=2, toggle in same cycle as accept -> next evt_cnt=1, evt_vld=1.
//  4 CNT_W=4, evt_rdy=0, 16 toggles -> evt_cnt=15, ovf=1; ovf_clr=1 with 17th toggle
//    -> ovf stays 1; ovf_clr alone -> ovf=0.
//  5 en=0 during 2 toggles, then en=1 with no toggle -> evt_vld=0; next toggle -> evt_cnt=1.
//  6 clr asserted mid-cycle with pend=5, ovf=1 -> evt_vld=0, evt_cnt=0, ovf=0
//    asynchronously.

Source files
------------

// File: rtl/nv_sync_toggle_evt_pkg.sv
// nv_sync_toggle_evt_pkg
//   Shared constants for the toggle-event consumer.
//   NV_STE_CNT_W : default width of the pending-event counter.
package nv_sync_toggle_evt_pkg;
    localparam int NV_STE_CNT_W = 4;
endpackage

// File: rtl/nv_sync_toggle_evt.sv
// nv_sync_toggle_evt
//   Sits right after a 3-flop synchronizer. Each transition of the synchronized
//   toggle is one source event. Events are coalesced into a saturating pending
//   count that is offered to a consumer over a valid/ready handshake. An event
//   that arrives while the count is saturated is lost and flags sticky ovf.
// Ports
//   clk       destination clock
//   clr       asynchronous active-high reset
//   tgl_sync  synchronized toggle
//   en        1: count edges, 0: drop edges (toggle tracking continues)
//   evt_rdy   consumer takes evt_cnt this cycle
//   ovf_clr   clears sticky ovf (a same-cycle set wins)
//   evt_vld   pending count nonzero
//   evt_cnt   pending count, meaningful while evt_vld
//   ovf       sticky overflow
module nv_sync_toggle_evt
    import nv_sync_toggle_evt_pkg::*;
#(
    parameter int CNT_W = NV_STE_CNT_W
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             tgl_sync,
    input  logic             en,
    input  logic             evt_rdy,
    input  logic             ovf_clr,
    output logic             evt_vld,
    output logic [CNT_W-1:0] evt_cnt,
    output logic             ovf
);

    logic             tgl_q;
    logic             armed;
    logic [CNT_W-1:0] pend;
    logic             ovf_q;
    logic             tgl_edge;
    logic             acc;
    logic             pend_max;

    // armed stays low for the first cycle after reset so the toggle level seen
    // at reset release is captured as the baseline rather than counted.
    assign tgl_edge = armed & en & (tgl_sync ^ tgl_q);
    assign acc      = evt_vld & evt_rdy;
    assign pend_max = (pend == {CNT_W{1'b1}});

    assign evt_vld  = (pend != '0);
    assign evt_cnt  = pend;
    assign ovf      = ovf_q;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            tgl_q <= 1'b0;
            armed <= 1'b0;
            pend  <= '0;
            ovf_q <= 1'b0;
        end else begin
            // Track the toggle even when disabled so re-enabling is edge-free.
            tgl_q <= tgl_sync;
            armed <= 1'b1;

            // An edge coinciding with an accept starts a fresh batch instead of
            // being folded into the count the consumer just took.
            if (acc)
                pend <= tgl_edge ? CNT_W'(1) : '0;
            else if (tgl_edge && !pend_max)
                pend <= pend + CNT_W'(1);

            if (!acc && tgl_edge && pend_max)
                ovf_q <= 1'b1;
            else if (ovf_clr)
                ovf_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_nv_sync_toggle_evt.sv
module tb_nv_sync_toggle_evt;

    logic       clk = 1'b0;
    logic       clr;
    logic       tgl_sync;
    logic       en;
    logic       evt_rdy;
    logic       ovf_clr;
    logic       evt_vld;
    logic [3:0] evt_cnt;
    logic       ovf;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       tgl;
        logic       en;
        logic       rdy;
        logic       oclr;
        logic       vld;
        logic [3:0] cnt;
        logic       ovf;
    } vec_t;

    vec_t vecs[$];
    logic lvl;

    nv_sync_toggle_evt #(.CNT_W(4)) dut (
        .clk      (clk),
        .clr      (clr),
        .tgl_sync (tgl_sync),
        .en       (en),
        .evt_rdy  (evt_rdy),
        .ovf_clr  (ovf_clr),
        .evt_vld  (evt_vld),
        .evt_cnt  (evt_cnt),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic v, input logic [3:0] c, input logic o);
        checks++;
        if ({evt_vld, evt_cnt, ovf} !== {v, c, o}) begin
            errors++;
            $display("FAIL %s: got vld=%0b cnt=%0d ovf=%0b, expected vld=%0b cnt=%0d ovf=%0b",
                     nm, evt_vld, evt_cnt, ovf, v, c, o);
        end
    endtask

    function automatic void add(input logic t, input logic e, input logic r, input logic oc,
                                input logic v, input logic [3:0] c, input logic o);
        vec_t x;
        x.tgl = t; x.en = e; x.rdy = r; x.oclr = oc;
        x.vld = v; x.cnt = c; x.ovf = o;
        vecs.push_back(x);
        lvl = t;
    endfunction

    // Drive one cycle of inputs just after an edge, then check after the next edge.
    task automatic step(input vec_t x, input string nm);
        tgl_sync = x.tgl; en = x.en; evt_rdy = x.rdy; ovf_clr = x.oclr;
        @(posedge clk); #1;
        chk(nm, x.vld, x.cnt, x.ovf);
    endtask

    initial begin
        // ---- table construction (expected values computed by hand) ----
        // 1: toggle held at 1 across reset release: never an event
        for (int i = 0; i < 10; i++) add(1, 1, 0, 0, 0, 0, 0);
        // 2: three toggles, then accept, then rdy with nothing pending
        add(0, 1, 0, 0, 1, 1, 0);
        add(1, 1, 0, 0, 1, 2, 0);
        add(0, 1, 0, 0, 1, 3, 0);
        add(0, 1, 1, 0, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0, 0);
        // 3: pend=2, toggle coincides with accept -> fresh batch of 1
        add(1, 1, 0, 0, 1, 1, 0);
        add(0, 1, 0, 0, 1, 2, 0);
        add(1, 1, 1, 0, 1, 1, 0);
        add(1, 1, 1, 0, 0, 0, 0);
        // 4: saturation; 16 toggles -> 15 with ovf
        for (int k = 1; k <= 16; k++)
            add(~lvl, 1, 0, 0, 1, (k > 15) ? 4'd15 : 4'(k), (k == 16));
        add(~lvl, 1, 0, 1, 1, 15, 1);    // set and clear together: set wins
        add(lvl, 1, 0, 1, 1, 15, 0);     // clear alone
        add(lvl, 1, 1, 0, 0, 0, 0);      // drain
        // 5: edges while disabled are dropped, re-enable is edge-free
        add(~lvl, 0, 0, 0, 0, 0, 0);
        add(~lvl, 0, 0, 0, 0, 0, 0);
        add(lvl, 1, 0, 0, 0, 0, 0);
        add(~lvl, 1, 0, 0, 1, 1, 0);
        add(lvl, 1, 1, 0, 0, 0, 0);
        // setup for 6: saturate, drain (ovf sticks), then pend=5
        for (int k = 1; k <= 16; k++)
            add(~lvl, 1, 0, 0, 1, (k > 15) ? 4'd15 : 4'(k), (k == 16));
        add(lvl, 1, 1, 0, 0, 0, 1);
        for (int k = 1; k <= 5; k++) add(~lvl, 1, 0, 0, 1, 4'(k), 1);

        // ---- reset with toggle high ----
        clr = 1'b1; tgl_sync = 1'b1; en = 1'b1; evt_rdy = 1'b0; ovf_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset", 0, 0, 0);
        clr = 1'b0;

        foreach (vecs[i]) step(vecs[i], $sformatf("vec%0d", i));

        // ---- 6: async clear mid-cycle with pend=5, ovf=1 ----
        #3;
        clr = 1'b1;
        #1;
        chk("async_clr", 0, 0, 0);
        @(posedge clk); #1;
        chk("clr_hold", 0, 0, 0);
        // Release with toggle level opposite to reset value: first cycle only arms.
        tgl_sync = ~lvl; en = 1'b1; evt_rdy = 1'b0; ovf_clr = 1'b0;
        clr = 1'b0;
        @(posedge clk); #1;
        chk("rearm", 0, 0, 0);
        @(posedge clk); #1;
        chk("rearm_idle", 0, 0, 0);
        tgl_sync = lvl;
        @(posedge clk); #1;
        chk("rearm_evt", 1, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
